// File: rtl/program_loader.sv
// Packs decoded instruction fields into 32-bit words and writes them to consecutive
// program-memory addresses from a base address, ahead of CPU fetch.
module program_loader #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDR_WIDTH        = 8,
  parameter int MEM_DEPTH         = 256
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [ADDR_WIDTH-1:0]        i_base_addr,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic                         i_in_last,
  input  logic [4:0]                   i_opcode,
  input  logic [8:0]                   i_destination,
  input  logic [8:0]                   i_source_1,
  input  logic [8:0]                   i_source_2,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] o_mem_wdata,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_overflow_err,
  output logic [ADDR_WIDTH:0]          o_count,
  output logic [ADDR_WIDTH:0]          o_alu_count,
  output logic [1:0]                   o_state
);

  // Handshake: a field set transfers on a rising edge where i_in_valid and o_in_ready are
  // both high; o_in_ready is registered and high exactly while the FSM is in LOAD.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t                          r_state;
  state_t                          w_next;
  logic [ADDR_WIDTH-1:0]           r_wr_ptr;
  logic                            r_in_ready;
  logic                            r_mem_we;
  logic [ADDR_WIDTH-1:0]           r_mem_addr;
  logic [INSTRUCTION_WIDTH-1:0]    r_mem_wdata;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_overflow_err;
  logic [ADDR_WIDTH:0]             r_count;
  logic [ADDR_WIDTH:0]             r_alu_count;

  logic                            w_accept;
  logic                            w_start_ok;
  logic                            w_at_end;
  logic                            w_is_alu;
  logic [INSTRUCTION_WIDTH-1:0]    w_packed;
  logic                            w_in_ready_d;
  logic                            w_busy_d;
  logic                            w_done_d;
  logic                            w_overflow_set;

  assign w_accept   = i_in_valid & r_in_ready;
  assign w_start_ok = i_start & (r_state != S_LOAD);
  assign w_at_end   = (r_wr_ptr == LAST_ADDR);
  assign w_is_alu   = (i_opcode >= 5'd1) && (i_opcode <= 5'd19);
  assign w_packed   = INSTRUCTION_WIDTH'({i_opcode, i_destination, i_source_1, i_source_2});

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_accept) begin
          if (i_in_last)     w_next = S_DONE;
          else if (w_at_end) w_next = S_ERROR;
        end
      end
      S_DONE:  w_next = i_start ? S_LOAD : S_IDLE;
      S_ERROR: if (i_start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    w_in_ready_d   = (w_next == S_LOAD);
    w_busy_d       = (w_next == S_LOAD);
    w_done_d       = w_accept & i_in_last;
    w_overflow_set = w_accept & ~i_in_last & w_at_end;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr       <= '0;
      r_in_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow_err <= 1'b0;
      r_count        <= '0;
      r_alu_count    <= '0;
    end else begin
      r_in_ready <= w_in_ready_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_mem_we   <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= r_wr_ptr;
        r_mem_wdata <= w_packed;
      end
      if (w_start_ok) begin
        r_wr_ptr       <= i_base_addr;
        r_count        <= '0;
        r_alu_count    <= '0;
        r_overflow_err <= 1'b0;
      end else begin
        // The pointer holds at the last address; the session ends there either way.
        if (w_accept && !w_at_end) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_accept) r_count <= r_count + CNT_ONE;
        if (w_accept && w_is_alu) r_alu_count <= r_alu_count + CNT_ONE;
        if (w_overflow_set) r_overflow_err <= 1'b1;
      end
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_overflow_err = r_overflow_err;
  assign o_count        = r_count;
  assign o_alu_count    = r_alu_count;
  assign o_state        = r_state;

endmodule
